// File: rtl/wrr_arbiter.sv
// Weighted round-robin arbiter: NUM requesters share one downstream port, each winner
// may run weight[id] back-to-back transfers. Optional macro WRR_LOCK_EN adds a lock input.
//
// state | meaning
// IDLE  | no grant outstanding, searching from ptr for a requester
// GRANT | grant held for the current winner until handshake or abort
module wrr_arbiter #(
    parameter  int NUM = 4,
    parameter  int WW  = 4,
    localparam int IDW = $clog2(NUM)
) (
    input  logic              clk,
    input  logic              reset,
    input  logic [NUM-1:0]    req,
    input  logic [NUM*WW-1:0] weight,
`ifdef WRR_LOCK_EN
    input  logic [NUM-1:0]    lock,
`endif
    input  logic              grant_ready,
    output logic [NUM-1:0]    grant,
    output logic              grant_valid,
    output logic [IDW-1:0]    grant_id
);

    typedef enum logic {IDLE, GRANT} state_t;

    state_t         state;
    logic [IDW-1:0] ptr;
    logic [WW-1:0]  credit;

    logic [IDW-1:0] nptr;
    logic [IDW-1:0] start;
    logic [IDW-1:0] win_id;
    logic           win_found;
    logic [WW-1:0]  win_w;
    logic [WW-1:0]  win_credit;
    logic [NUM-1:0] win_onehot;
    int             k_idx;

    assign grant_valid = |grant;

    // On rotation the search starts just past the current owner, in the same cycle,
    // so a pending request is granted without an idle bubble.
    always_comb begin
        nptr       = (grant_id == IDW'(NUM-1)) ? '0 : grant_id + IDW'(1);
        start      = (state == GRANT) ? nptr : ptr;
        win_found  = 1'b0;
        win_id     = '0;
        k_idx      = 0;
        for (int i = 0; i < NUM; i++) begin
            k_idx = int'(start) + i;
            if (k_idx >= NUM) k_idx = k_idx - NUM;
            if (!win_found && req[k_idx]) begin
                win_found = 1'b1;
                win_id    = IDW'(k_idx);
            end
        end
        win_w      = weight[int'(win_id)*WW +: WW];
        win_credit = (win_w == '0) ? WW'(1) : win_w;
        win_onehot = NUM'(1) << win_id;
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state    <= IDLE;
            grant    <= '0;
            grant_id <= '0;
            ptr      <= '0;
            credit   <= '0;
        end else begin
            case (state)
                IDLE: begin
                    if (win_found) begin
                        grant    <= win_onehot;
                        grant_id <= win_id;
                        credit   <= win_credit;
                        state    <= GRANT;
                    end
                end
                GRANT: begin
                    if (grant_ready) begin
`ifdef WRR_LOCK_EN
                        if (lock[grant_id]) credit <= WW'(1);
                        else
`endif
                        if (credit > WW'(1) && req[grant_id]) begin
                            credit <= credit - WW'(1);
                        end else begin
                            ptr <= nptr;
                            if (win_found) begin
                                grant    <= win_onehot;
                                grant_id <= win_id;
                                credit   <= win_credit;
                            end else begin
                                grant    <= '0;
                                grant_id <= '0;
                                credit   <= '0;
                                state    <= IDLE;
                            end
                        end
                    end else if (!req[grant_id]) begin
                        // requester withdrew without a transfer: drop the burst
                        grant    <= '0;
                        grant_id <= '0;
                        credit   <= '0;
                        ptr      <= nptr;
                        state    <= IDLE;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule
